// File: rtl/sea_pkg.sv
// Shared SEA definitions: S-box, word/triple helpers and the FSM state encoding.
package sea_pkg;

    // Helpers work on words up to this width; B must not exceed it.
    localparam int unsigned WMAX = 32;

    // 3-bit S-box {0,5,6,7,4,3,1,2}, entry e at bits [3e+2:3e].
    localparam logic [23:0] SBOX = {3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEXP  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [WMAX-1:0] word_t;

    // One word triple (x3i, x3i+1, x3i+2); w0 carries the S-box LSB.
    typedef struct packed {
        word_t w2;
        word_t w1;
        word_t w0;
    } sea_tri_t;

    // Mask of the low b bits (b = WMAX yields all ones through wrap).
    function automatic word_t wmask(input int unsigned b);
        return (word_t'(1) << b) - word_t'(1);
    endfunction

    // Word addition mod 2^b.
    function automatic word_t add_w(input word_t a, input word_t c, input int unsigned b);
        return (a + c) & wmask(b);
    endfunction

    // Rotate a b-bit word right by one.
    function automatic word_t rotr1_w(input word_t x, input int unsigned b);
        return ((x >> 1) | (word_t'(x[0]) << (b - 1))) & wmask(b);
    endfunction

    // Rotate a b-bit word left by one.
    function automatic word_t rotl1_w(input word_t x, input int unsigned b);
        return ((x << 1) | (x >> (b - 1))) & wmask(b);
    endfunction

    // Bit-sliced S-box over a triple; unused upper bits map 0 -> 0.
    function automatic sea_tri_t sbox_t(input sea_tri_t x);
        sea_tri_t    y;
        logic [2:0]  s;
        int unsigned e;
        y = '0;
        for (int unsigned k = 0; k < WMAX; k++) begin
            e = 32'({x.w2[k], x.w1[k], x.w0[k]});
            s = SBOX[3*e +: 3];
            y.w0[k] = s[0];
            y.w1[k] = s[1];
            y.w2[k] = s[2];
        end
        return y;
    endfunction

    // r(S(t)): S-box then the in-triple bit rotations.
    function automatic sea_tri_t tri_rs(input sea_tri_t t, input int unsigned b);
        sea_tri_t y;
        y    = sbox_t(t);
        y.w0 = rotr1_w(y.w0, b);
        y.w2 = rotl1_w(y.w2, b);
        return y;
    endfunction

endpackage

// File: rtl/sea_round.sv
// Combinational SEA round for block and key, forward or inverse.
module sea_round
    import sea_pkg::*;
#(
    parameter int unsigned N  = 96,
    parameter int unsigned B  = 8,
    parameter int unsigned NB = N / (2 * B),
    parameter int unsigned CW = 7
) (
    input  logic          i_inv,
    input  logic [CW-1:0] i_idx,
    input  logic [N-1:0]  i_blk,
    input  logic [N-1:0]  i_key,
    output logic [N-1:0]  o_blk_c,
    output logic [N-1:0]  o_key_c
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned NT = NB / 3;

    // r(S(X + K)) over a half-block.
    function automatic logic [H-1:0] half_f(input logic [H-1:0] k, input logic [H-1:0] x);
        logic [H-1:0] a;
        logic [H-1:0] y;
        sea_tri_t     t;
        a = '0;
        y = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            a[j*B +: B] = B'(add_w(word_t'(x[j*B +: B]), word_t'(k[j*B +: B]), B));
        end
        for (int unsigned g = 0; g < NT; g++) begin
            t.w0 = word_t'(a[(3*g)*B +: B]);
            t.w1 = word_t'(a[(3*g+1)*B +: B]);
            t.w2 = word_t'(a[(3*g+2)*B +: B]);
            t    = tri_rs(t, B);
            y[(3*g)*B +: B]   = B'(t.w0);
            y[(3*g+1)*B +: B] = B'(t.w1);
            y[(3*g+2)*B +: B] = B'(t.w2);
        end
        return y;
    endfunction

    // Word rotation: output word (j+1) mod NB takes input word j.
    function automatic logic [H-1:0] rot_w(input logic [H-1:0] x);
        logic [H-1:0] y;
        y = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            y[((j + 1) % NB)*B +: B] = x[j*B +: B];
        end
        return y;
    endfunction

    // Inverse word rotation.
    function automatic logic [H-1:0] rot_w_inv(input logic [H-1:0] x);
        logic [H-1:0] y;
        y = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            y[j*B +: B] = x[((j + 1) % NB)*B +: B];
        end
        return y;
    endfunction

    // Round constant: index in word 0, zero elsewhere.
    function automatic logic [H-1:0] rc(input logic [CW-1:0] idx);
        logic [H-1:0] c;
        c        = '0;
        c[B-1:0] = B'(idx);
        return c;
    endfunction

    logic [H-1:0] w_l;
    logic [H-1:0] w_r;
    logic [H-1:0] w_kl;
    logic [H-1:0] w_kr;
    logic [H-1:0] w_kx;
    logic [H-1:0] w_fx;
    logic [H-1:0] w_g;
    logic [H-1:0] w_f;

    assign w_l  = i_blk[N-1:H];
    assign w_r  = i_blk[H-1:0];
    assign w_kl = i_key[N-1:H];
    assign w_kr = i_key[H-1:0];

    // Forward keys off KR; inverse keys off KL, which is the restored KR.
    assign w_kx = i_inv ? w_kl : w_kr;
    assign w_fx = i_inv ? w_l  : w_r;
    assign w_g  = rot_w(half_f(rc(i_idx), w_kx));
    assign w_f  = half_f(w_kx, w_fx);

    // Select forward or inverse updates for key and block.
    always_comb begin
        o_key_c = i_key;
        o_blk_c = i_blk;
        if (i_inv) begin
            o_key_c = {w_kr ^ w_g, w_kl};
            o_blk_c = {rot_w_inv(w_r ^ w_f), w_l};
        end else begin
            o_key_c = {w_kr, w_kl ^ w_g};
            o_blk_c = {w_r, rot_w(w_l) ^ w_f};
        end
    end

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA engine: one round per enabled clock, encrypt or decrypt.
module sea_iter_core
    import sea_pkg::*;
#(
    parameter int unsigned N  = 96,
    parameter int unsigned B  = 8,
    parameter int unsigned NB = N / (2 * B),
    parameter int unsigned NR = 3 * N / 4 + 2 * (NB + B / 2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] din,
    input  logic [N-1:0] key,
    output logic [N-1:0] dout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(NR + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mode;
    logic [N-1:0]  r_blk;
    logic [N-1:0]  r_key;
    logic          w_load;
    logic          w_step_key;
    logic          w_step_blk;
    logic          w_out;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_last;
    logic          w_inv;
    logic [CW-1:0] w_idx;
    logic [N-1:0]  w_blk_nxt;
    logic [N-1:0]  w_key_nxt;

    // Decrypt rounds run the counter from NR down, so the index is one below it.
    assign w_inv = (r_state == ST_ROUND) && r_mode;
    assign w_idx = w_inv ? (r_cnt - CW'(1)) : r_cnt;

    sea_round #(
        .N  (N),
        .B  (B),
        .NB (NB),
        .CW (CW)
    ) u_round (
        .i_inv   (w_inv),
        .i_idx   (w_idx),
        .i_blk   (r_blk),
        .i_key   (r_key),
        .o_blk_c (w_blk_nxt),
        .o_key_c (w_key_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter and datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_step_key  = 1'b0;
        w_step_blk  = 1'b0;
        w_out       = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = mode ? ST_KEXP : ST_ROUND;
                end
            end
            ST_KEXP: begin
                w_step_key = 1'b1;
                w_busy_nxt = 1'b1;
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CW'(NR - 1)) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_step_key = 1'b1;
                w_step_blk = 1'b1;
                if (r_mode) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                    w_last    = (r_cnt == CW'(1));
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_last    = (r_cnt == CW'(NR - 1));
                end
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_out       = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_blk  <= '0;
            r_key  <= '0;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (ena) begin
            r_cnt <= w_cnt_nxt;
            busy  <= w_busy_nxt;
            done  <= w_done_nxt;
            if (w_load) begin
                r_blk  <= din;
                r_key  <= key;
                r_mode <= mode;
            end else begin
                if (w_step_key) begin
                    r_key <= w_key_nxt;
                end
                if (w_step_blk) begin
                    r_blk <= w_blk_nxt;
                end
            end
            if (w_out) begin
                dout <= r_blk;
            end
        end
    end

endmodule
